// File: rtl/lsu_misalign.sv
// Load/store unit: passes aligned accesses to byte-banked data memory, splits misaligned ones.
// Latency: error 1, aligned 2, misaligned load 3, misaligned SH 3, misaligned SW 5 cycles.
// Backpressure: req_ready is high only in IDLE; one request in flight at a time.
module lsu_misalign #(
    parameter int MISALIGN_SPLIT = 1,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    output logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_rd
);

    typedef enum logic [2:0] {IDLE, ALIGNED, LD_LO, LD_HI, ST_BYTE, RESP} state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_a_q, mem_a_d;
    logic [XLEN-1:0] mem_wd_q, mem_wd_d;
    logic [2:0]      mem_f3_q, mem_f3_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;

    logic            req_legal;
    logic            req_misal;
    logic [1:0]      cnt_last;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_merge;

    // Decode the incoming request and merge the two words of a split load
    always_comb begin
        if (req_we) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                        (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
        req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        // Half stores split into 2 bytes, word stores into 4
        cnt_last  = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
        // {hi, lo} shifted down by the byte offset; only the low word is ever needed
        ld_shift  = 32'({mem_rd, lo_q} >> {addr_q[1:0], 3'b000});
        if (f3_q[1:0] == 2'b10) begin
            ld_merge = ld_shift;
        end else if (f3_q[2]) begin
            ld_merge = {16'b0, ld_shift[15:0]};
        end else begin
            ld_merge = {{16{ld_shift[15]}}, ld_shift[15:0]};
        end
    end

    // Next-state logic; memory and response outputs are computed one cycle ahead so they leave flops
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
        mem_we_d     = 1'b0;
        mem_a_d      = '0;
        mem_wd_d     = '0;
        mem_f3_d     = 3'b010;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (!req_legal || (req_misal && (MISALIGN_SPLIT == 0))) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!req_misal) begin
                        state_d  = ALIGNED;
                        mem_we_d = req_we;
                        mem_a_d  = req_addr;
                        mem_wd_d = req_wdata;
                        mem_f3_d = req_funct3;
                    end else if (req_we) begin
                        state_d  = ST_BYTE;
                        cnt_d    = 2'd0;
                        mem_we_d = 1'b1;
                        mem_f3_d = 3'b000;
                        mem_a_d  = req_addr;
                        mem_wd_d = {24'b0, req_wdata[7:0]};
                    end else begin
                        state_d = LD_LO;
                        mem_a_d = {req_addr[XLEN-1:2], 2'b00};
                    end
                end
            end
            ALIGNED: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                if (!we_q) begin
                    resp_rdata_d = mem_rd;
                end
            end
            LD_LO: begin
                state_d = LD_HI;
                lo_d    = mem_rd;
                mem_a_d = {addr_q[XLEN-1:2], 2'b00} + 32'd4;
            end
            LD_HI: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_merge;
            end
            ST_BYTE: begin
                if (cnt_q == cnt_last) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 2'd1;
                    mem_we_d = 1'b1;
                    mem_f3_d = 3'b000;
                    mem_a_d  = addr_q + {30'b0, cnt_d};
                    mem_wd_d = {24'b0, wdata_q[{cnt_d, 3'b000} +: 8]};
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight without a response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            cnt_q        <= 2'd0;
            mem_we_q     <= 1'b0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            mem_f3_q     <= 3'b010;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            mem_f3_q     <= mem_f3_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_we     = mem_we_q;
    assign mem_a      = mem_a_q;
    assign mem_wd     = mem_wd_q;
    assign mem_funct3 = mem_f3_q;

endmodule

// File: doc/lsu_misalign.md
Name: lsu_misalign

Overview:
- Load/store unit on the CPU side of the data-memory interface. It takes one load or store request per handshake from the execute stage and drives the byte-banked data memory.
- Memory port: address, write data, write enable, funct3 in; combinational read data out; writes commit at posedge.
- Aligned accesses pass straight through in one memory cycle.
- Misaligned halfword/word accesses are split: loads become two aligned word reads, stores become a series of byte stores. This gives the core full RV32I misaligned load/store support without trapping.

Parameters:
- MISALIGN_SPLIT, 1, 1 = split misaligned accesses; 0 = reject them with resp_err and no memory access.
- XLEN, 32, data/address width; fixed at 32 for RV32I.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bytes used for SB/SH
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  extended load result; 0 for stores/errors
- resp_err  out  1  qualifies resp_valid: illegal funct3, or misaligned with MISALIGN_SPLIT=0
- mem_we  out  1  memory write enable
- mem_a  out  32  memory address
- mem_wd  out  32  memory write data
- mem_funct3  out  3  memory access size
- mem_rd  in  32  combinational memory read data for mem_a/mem_funct3

Behaviour:
- Reset values: FSM = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0, mem_a = 0, mem_wd = 0, mem_funct3 = 3'b010.
- Reset is asynchronous and may arrive mid-operation. mem_we drops immediately. Byte stores already committed stay in memory. No response is issued for the aborted request.
- States: IDLE, ALIGNED, LD_LO, LD_HI, ST_BYTE, RESP.
- Acceptance: req_valid && req_ready at a posedge. Request fields are latched at that edge. req_ready is 1 only in IDLE.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Any other value goes IDLE -> RESP with err = 1 and no memory cycle.
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0. Bytes are never misaligned.
  - With MISALIGN_SPLIT = 0, a misaligned request goes IDLE -> RESP with err = 1.
- ALIGNED (1 cycle): drives mem_a = addr, mem_funct3 = funct3, mem_wd = wdata, mem_we = we. For loads, mem_rd is captured at the end of the cycle. Next state is RESP.
- LD_LO (1 cycle): drives mem_a = {addr[31:2], 2'b00}, mem_funct3 = 010; lo word captured. Next state is LD_HI.
- LD_HI (1 cycle): drives mem_a = {addr[31:2], 2'b00} + 4, with 32-bit wrap (0xFFFFFFFD -> hi word at 0x00000000); hi word captured. Next state is RESP.
- Load merge: form the 64-bit value {hi, lo}, shift right by 8*addr[1:0], take the low 16 or 32 bits.
  - LH sign-extends from bit 15; LHU zero-extends.
- ST_BYTE: one byte store per cycle, mem_funct3 = 000, mem_we = 1, mem_a = addr + i, mem_wd = {24'b0, wdata[8i+:8]}.
  - i runs 0..N-1, with N = 2 (SH) or 4 (SW), held in a 2-bit counter.
  - Next state is RESP after byte N-1.
- RESP (1 cycle): resp_valid = 1, with resp_rdata/resp_err valid. Next state is IDLE. The next request can be accepted one cycle later.
- Latency from the acceptance edge to resp_valid high:
  - aligned: 2 cycles
  - misaligned load: 3 cycles
  - misaligned SH: 3 cycles
  - misaligned SW: 5 cycles
  - error: 1 cycle
- Outside the memory states, mem_we = 0 and mem_* keep their reset values. mem_we is never high in load states.

Test Plan:
- Aligned LW 0x00000004, mem[0x4] = 0x44332211 -> one memory cycle with mem_funct3 = 010, mem_we = 0; resp_valid 2 cycles after acceptance, resp_rdata = 0x44332211, resp_err = 0.
- Misaligned LW 0x00000005, mem[0x4] = 0x44332211, mem[0x8] = 0x88776655 -> mem_a = 0x4 then 0x8; resp_rdata = 0x55443322 after 3 cycles.
- Misaligned LH / LHU 0x00000007, mem[0x4] = 0x80332211, mem[0x8] = 0x000000F1 -> LH returns 0xFFFFF180, LHU returns 0x0000F180.
- Misaligned SW 0xAABBCCDD at 0x00000006 -> four cycles with mem_we = 1, mem_funct3 = 000, (mem_a, mem_wd[7:0]) = (6, DD), (7, CC), (8, BB), (9, AA); resp_valid on cycle 5; a later LW at 0x6 returns 0xAABBCCDD.
- Illegal funct3 = 011 load, and with MISALIGN_SPLIT = 0 an LW at 0x1 -> no memory cycle, resp_valid 1 cycle later, resp_err = 1, resp_rdata = 0.
- Reset asserted in the 2nd cycle of the misaligned SW -> mem_we = 0 immediately, req_ready = 1 after reset; only byte 0x6 = DD is modified.
